// File: rtl/sic_alu_lock_arbiter_pkg.sv
// Shared types for the SIC/ALU lock arbiter: ALU request/answer, slot owner record,
// and the wrap-aware issue-id age compare reused by other age-ordered arbiters.
package sic_alu_lock_arbiter_pkg;

  localparam int ALU_DATA_W  = 16;
  localparam int OWNER_IDX_W = 8;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  typedef struct packed {
    logic                  valid;
    alu_op_e               op;
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
  } alu_req_t;

  typedef struct packed {
    logic                  valid;
    logic [ALU_DATA_W-1:0] result;
  } alu_ans_t;

  typedef struct packed {
    logic                   valid;
    logic [OWNER_IDX_W-1:0] idx;
  } alu_owner_t;

  // a is older than b when (a-b), taken at 'width' bits, is negative.
  function automatic logic issue_id_older(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [31:0] diff;
    diff = a - b;
    return diff[width-1];
  endfunction

endpackage

// File: rtl/sic_alu_lock_arbiter_age_picker.sv
// sic_age_picker: combinational one-hot pick of the oldest eligible SIC.
// Age ordering only when SIC_ALU_ARB_AGE_PRIORITY_EN is defined, else lowest index wins.
module sic_age_picker
  import sic_alu_lock_arbiter_pkg::*;
#(
  parameter int NUM_SIC  = 4,
  parameter int ID_WIDTH = 8
) (
  input  logic [NUM_SIC-1:0]  i_elig,
  input  logic [ID_WIDTH-1:0] i_ids [NUM_SIC],
  output logic [NUM_SIC-1:0]  o_pick
);

  logic [NUM_SIC-1:0] w_first;

  // Lowest-index eligible requester.
  always_comb begin : p_first
    logic found;
    found   = 1'b0;
    w_first = '0;
    for (int i = 0; i < NUM_SIC; i++) begin
      w_first[i] = i_elig[i] & ~found;
      found      = found | i_elig[i];
    end
  end

`ifdef SIC_ALU_ARB_AGE_PRIORITY_EN
  logic [NUM_SIC-1:0] w_win;

  // A SIC wins when no other eligible SIC is older, equal ids going to the lower index.
  always_comb begin
    w_win = '0;
    for (int i = 0; i < NUM_SIC; i++) begin
      w_win[i] = i_elig[i];
      for (int j = 0; j < NUM_SIC; j++) begin
        w_win[i] = w_win[i] & ~(i_elig[j] & (j != i) &
                   (issue_id_older(32'(i_ids[j]), 32'(i_ids[i]), ID_WIDTH) |
                    ((i_ids[j] == i_ids[i]) & (j < i))));
      end
    end
  end

  // Wrapped ids can form an age cycle with no winner; fall back to index order then.
  assign o_pick = (|w_win) ? w_win : w_first;
`else
  logic w_unused_ids;

  // Ids carry no meaning in fixed-priority mode.
  always_comb begin
    w_unused_ids = 1'b0;
    for (int i = 0; i < NUM_SIC; i++) begin
      w_unused_ids = w_unused_ids ^ (^i_ids[i]);
    end
  end

  assign o_pick = w_first;
`endif

endmodule

// File: rtl/sic_alu_lock_arbiter.sv
// Lock arbiter sharing NUM_ALU ALUs among NUM_SIC SICs, with op/answer routing.
// Ordering selected by SIC_ALU_ARB_AGE_PRIORITY_EN (age) or fixed low-index priority.
module sic_alu_lock_arbiter
  import sic_alu_lock_arbiter_pkg::*;
#(
  parameter int NUM_SIC  = 4,
  parameter int NUM_ALU  = 2,
  parameter int ID_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SIC-1:0]  i_req,
  input  logic [ID_WIDTH-1:0] i_req_issue_id [NUM_SIC],
  input  logic [NUM_SIC-1:0]  i_release_lock,
  output logic [NUM_SIC-1:0]  o_grant,
  input  alu_req_t            i_sic_alu_req [NUM_SIC],
  output alu_ans_t            o_sic_alu_ans [NUM_SIC],
  output alu_req_t            o_alu_req_out [NUM_ALU],
  input  alu_ans_t            i_alu_ans_in [NUM_ALU],
  output logic [NUM_ALU-1:0]  o_alu_busy
);

  localparam int IDX_W = (NUM_SIC > 1) ? $clog2(NUM_SIC) : 1;

  logic [NUM_ALU-1:0] r_owner_valid;
  logic [IDX_W-1:0]   r_owner_idx [NUM_ALU];
  logic [NUM_SIC-1:0] r_grant;

  logic [NUM_SIC-1:0] w_elig;
  logic [NUM_SIC-1:0] w_pick [NUM_ALU];
  logic [IDX_W-1:0]   w_pick_idx [NUM_ALU];
  logic [NUM_ALU-1:0] w_nxt_valid;
  logic [IDX_W-1:0]   w_nxt_idx [NUM_ALU];
  logic [NUM_SIC-1:0] w_nxt_grant;

  // r_grant mirrors ownership, so it doubles as the "already owns a slot" mask.
  assign w_elig = i_req & ~r_grant & ~i_release_lock;

  for (genvar k = 0; k < NUM_ALU; k++) begin : g_slot
    logic [NUM_SIC-1:0] w_mask_in;
    logic [NUM_SIC-1:0] w_pick_s;
    logic [NUM_SIC-1:0] w_mask_out;
    logic [IDX_W-1:0]   w_idx_s;

    if (k == 0) begin : g_head
      assign w_mask_in = w_elig;
    end else begin : g_tail
      assign w_mask_in = g_slot[k-1].w_mask_out;
    end

    sic_age_picker #(
      .NUM_SIC  (NUM_SIC),
      .ID_WIDTH (ID_WIDTH)
    ) u_picker (
      .i_elig (w_mask_in),
      .i_ids  (i_req_issue_id),
      .o_pick (w_pick_s)
    );

    // Only a slot free at cycle start consumes its pick.
    assign w_mask_out = r_owner_valid[k] ? w_mask_in : (w_mask_in & ~w_pick_s);

    // One-hot to index.
    always_comb begin
      w_idx_s = '0;
      for (int i = 0; i < NUM_SIC; i++) begin
        w_idx_s = w_idx_s | ({IDX_W{w_pick_s[i]}} & IDX_W'(i));
      end
    end

    assign w_pick[k]     = w_pick_s;
    assign w_pick_idx[k] = w_idx_s;
  end

  // Next owner state: owned slots drop only on their owner's release, free slots take their pick.
  always_comb begin
    w_nxt_valid = r_owner_valid;
    w_nxt_idx   = r_owner_idx;
    w_nxt_grant = '0;
    for (int k = 0; k < NUM_ALU; k++) begin
      if (r_owner_valid[k]) begin
        w_nxt_valid[k] = ~i_release_lock[r_owner_idx[k]];
      end else begin
        w_nxt_valid[k] = |w_pick[k];
        w_nxt_idx[k]   = w_pick_idx[k];
      end
    end
    for (int k = 0; k < NUM_ALU; k++) begin
      for (int i = 0; i < NUM_SIC; i++) begin
        w_nxt_grant[i] = w_nxt_grant[i] | (w_nxt_valid[k] & (w_nxt_idx[k] == IDX_W'(i)));
      end
    end
  end

  // Owner state and registered grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_valid <= '0;
      r_grant       <= '0;
      for (int k = 0; k < NUM_ALU; k++) begin
        r_owner_idx[k] <= '0;
      end
    end else begin
      r_owner_valid <= w_nxt_valid;
      r_grant       <= w_nxt_grant;
      r_owner_idx   <= w_nxt_idx;
    end
  end

  assign o_grant    = r_grant;
  assign o_alu_busy = r_owner_valid;

  // Zero-latency routing between each owner and its ALU.
  always_comb begin
    for (int k = 0; k < NUM_ALU; k++) begin
      o_alu_req_out[k] = r_owner_valid[k] ? i_sic_alu_req[r_owner_idx[k]] : alu_req_t'('0);
    end
    for (int i = 0; i < NUM_SIC; i++) begin
      o_sic_alu_ans[i] = alu_ans_t'('0);
      for (int k = 0; k < NUM_ALU; k++) begin
        o_sic_alu_ans[i] = o_sic_alu_ans[i] |
          ((r_owner_valid[k] && (r_owner_idx[k] == IDX_W'(i))) ? i_alu_ans_in[k] : alu_ans_t'('0));
      end
    end
  end

  sic_alu_lock_arbiter_chk #(
    .NUM_ALU (NUM_ALU),
    .IDX_W   (IDX_W)
  ) u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_owner_valid (r_owner_valid),
    .i_owner_idx   (r_owner_idx)
  );

endmodule

// Debug checker: no SIC may own two slots at once.
module sic_alu_lock_arbiter_chk #(
  parameter int NUM_ALU = 2,
  parameter int IDX_W   = 2
) (
  input logic               clk,
  input logic               rst_n,
  input logic [NUM_ALU-1:0] i_owner_valid,
  input logic [IDX_W-1:0]   i_owner_idx [NUM_ALU]
);

  logic w_dup;

  // Pairwise duplicate-owner detection.
  always_comb begin
    w_dup = 1'b0;
    for (int k = 0; k < NUM_ALU; k++) begin
      for (int m = k + 1; m < NUM_ALU; m++) begin
        w_dup = w_dup | (i_owner_valid[k] & i_owner_valid[m] &
                         (i_owner_idx[k] == i_owner_idx[m]));
      end
    end
  end

  a_single_slot_per_sic: assert property (@(posedge clk) disable iff (!rst_n) !w_dup);

endmodule

// File: tb/tb_sic_alu_lock_arbiter.sv
// Directed scoreboard bench for sic_alu_lock_arbiter; expectations follow
// SIC_ALU_ARB_AGE_PRIORITY_EN (age order) or its absence (fixed priority).
module tb_sic_alu_lock_arbiter;
  import sic_alu_lock_arbiter_pkg::*;

`ifdef SIC_ALU_ARB_AGE_PRIORITY_EN
  localparam logic [3:0] OVR_GRANT = 4'b1010;
  localparam int         OVR_OWN0  = 1;
  localparam int         OVR_OWN1  = 3;
  localparam logic [3:0] HO_G1     = 4'b1000;
  localparam logic [1:0] HO_B1     = 2'b10;
  localparam logic [3:0] HO_G2     = 4'b1100;
  localparam int         HO_SLOT   = 0;
  localparam logic [1:0] WR_G1     = 2'b10;
`else
  localparam logic [3:0] OVR_GRANT = 4'b0011;
  localparam int         OVR_OWN0  = 0;
  localparam int         OVR_OWN1  = 1;
  localparam logic [3:0] HO_G1     = 4'b0001;
  localparam logic [1:0] HO_B1     = 2'b01;
  localparam logic [3:0] HO_G2     = 4'b0101;
  localparam int         HO_SLOT   = 1;
  localparam logic [1:0] WR_G1     = 2'b01;
`endif

  logic clk;
  logic rst_n;

  logic [3:0] a_req, a_rel, a_grant;
  logic [7:0] a_id [4];
  alu_req_t   a_sreq [4];
  alu_ans_t   a_sans [4];
  alu_req_t   a_areq [2];
  alu_ans_t   a_aans [2];
  logic [1:0] a_busy;

  logic [1:0] b_req, b_rel, b_grant;
  logic [7:0] b_id [2];
  alu_req_t   b_sreq [2];
  alu_ans_t   b_sans [2];
  alu_req_t   b_areq [1];
  alu_ans_t   b_aans [1];
  logic [0:0] b_busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;
  exp_t sb_q[$];

  sic_alu_lock_arbiter #(.NUM_SIC(4), .NUM_ALU(2), .ID_WIDTH(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_req(a_req), .i_req_issue_id(a_id),
    .i_release_lock(a_rel), .o_grant(a_grant), .i_sic_alu_req(a_sreq),
    .o_sic_alu_ans(a_sans), .o_alu_req_out(a_areq), .i_alu_ans_in(a_aans),
    .o_alu_busy(a_busy)
  );

  sic_alu_lock_arbiter #(.NUM_SIC(2), .NUM_ALU(1), .ID_WIDTH(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_req(b_req), .i_req_issue_id(b_id),
    .i_release_lock(b_rel), .o_grant(b_grant), .i_sic_alu_req(b_sreq),
    .o_sic_alu_ans(b_sans), .o_alu_req_out(b_areq), .i_alu_ans_in(b_aans),
    .o_alu_busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic alu_req_t mk_req(input int i);
    alu_req_t r;
    r.valid = 1'b1;
    r.op    = ALU_ADD;
    r.a     = 16'(100 + i);
    r.b     = 16'(i);
    return r;
  endfunction

  function automatic alu_ans_t mk_ans(input logic [15:0] v);
    alu_ans_t r;
    r.valid  = 1'b1;
    r.result = v;
    return r;
  endfunction

  task automatic push_exp(input string tag, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      $error("FAIL sb_empty: observed %h with no expectation queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  function automatic logic [63:0] st_a();
    return 64'({a_grant, a_busy});
  endfunction

  function automatic logic [63:0] st_b();
    return 64'({b_grant, b_busy});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    a_req = '0; a_rel = '0; b_req = '0; b_rel = '0;
    a_id[0] = 8'd0; a_id[1] = 8'd0; a_id[2] = 8'd0; a_id[3] = 8'd0;
    b_id[0] = 8'd0; b_id[1] = 8'd0;
    for (int i = 0; i < 4; i++) a_sreq[i] = mk_req(i);
    for (int i = 0; i < 2; i++) b_sreq[i] = mk_req(i);
    a_aans[0] = mk_ans(16'hA000);
    a_aans[1] = mk_ans(16'hB001);
    b_aans[0] = mk_ans(16'hC002);
    #1 rst_n = 1'b0;
    #1;
    push_exp("reset_state", 64'd0);        pop_check(st_a());
    push_exp("reset_req_out0", 64'd0);     pop_check(64'(a_areq[0]));
    push_exp("reset_sic_ans1", 64'd0);     pop_check(64'(a_sans[1]));
    tick();
    rst_n = 1'b1;
    tick();

    // Single requester
    a_req = 4'b0010; a_id[1] = 8'd5;
    push_exp("single_no_early_grant", 64'd0); pop_check(st_a());
    push_exp("single_grant", 64'({4'b0010, 2'b01}));
    tick();                                         pop_check(st_a());
    push_exp("single_route_req0", 64'(mk_req(1)));  pop_check(64'(a_areq[0]));
    push_exp("single_route_ans1", 64'(mk_ans(16'hA000))); pop_check(64'(a_sans[1]));
    push_exp("single_nonowner_ans0", 64'd0);        pop_check(64'(a_sans[0]));
    a_rel = 4'b0010; a_req = 4'b0000;
    push_exp("single_release", 64'd0);
    tick();                                         pop_check(st_a());
    a_rel = 4'b0000;

    // Oversubscription
    a_req = 4'b1111;
    a_id[0] = 8'd9; a_id[1] = 8'd3; a_id[2] = 8'd7; a_id[3] = 8'd4;
    push_exp("ovr_grant", 64'({OVR_GRANT, 2'b11}));
    tick();                                           pop_check(st_a());
    push_exp("ovr_slot0", 64'(mk_req(OVR_OWN0)));     pop_check(64'(a_areq[0]));
    push_exp("ovr_slot1", 64'(mk_req(OVR_OWN1)));     pop_check(64'(a_areq[1]));
    push_exp("ovr_hold", 64'({OVR_GRANT, 2'b11}));
    tick();                                           pop_check(st_a());

    // Release then handoff
    a_rel = 4'b0010; a_req = 4'b1101;
    push_exp("handoff_m1", 64'({HO_G1, HO_B1}));
    tick();                                           pop_check(st_a());
    a_rel = 4'b0000;
    push_exp("handoff_m2", 64'({HO_G2, 2'b11}));
    tick();                                           pop_check(st_a());
    push_exp("handoff_route", 64'(mk_req(2)));        pop_check(64'(a_areq[HO_SLOT]));

    // Clear everything, then abort / stray release
    a_rel = 4'b1111; a_req = 4'b0000;
    push_exp("release_all", 64'd0);
    tick();                                           pop_check(st_a());
    a_rel = 4'b0000; a_req = 4'b0010;
    push_exp("abort_setup", 64'({4'b0010, 2'b01}));
    tick();                                           pop_check(st_a());
    a_rel = 4'b1001;
    push_exp("abort_stray", 64'({4'b0010, 2'b01}));
    tick();                                           pop_check(st_a());
    a_rel = 4'b0000; a_req = 4'b0000;
    push_exp("sticky_lock", 64'({4'b0010, 2'b01}));
    tick();                                           pop_check(st_a());
    a_req = 4'b0100; a_rel = 4'b0100;
    push_exp("req_rel_same_cycle", 64'({4'b0010, 2'b01}));
    tick();                                           pop_check(st_a());
    a_rel = 4'b0000;
    push_exp("req_after_release", 64'({4'b0110, 2'b11}));
    tick();                                           pop_check(st_a());

    // Routing for SIC2 on slot 1
    a_sreq[2].op = ALU_ADD; a_sreq[2].a = 16'd10; a_sreq[2].b = 16'd3;
    a_aans[1] = mk_ans(16'd13);
    #1;
    begin
      alu_req_t e;
      e.valid = 1'b1; e.op = ALU_ADD; e.a = 16'd10; e.b = 16'd3;
      push_exp("route_req_out1", 64'(e));             pop_check(64'(a_areq[1]));
    end
    push_exp("route_sic_ans2", 64'(mk_ans(16'd13)));  pop_check(64'(a_sans[2]));
    push_exp("route_req_out0", 64'(mk_req(1)));       pop_check(64'(a_areq[0]));

    // Asynchronous reset mid-lock
    #2 rst_n = 1'b0;
    #1;
    push_exp("midlock_reset_state", 64'd0);   pop_check(st_a());
    push_exp("midlock_reset_out1", 64'd0);    pop_check(64'(a_areq[1]));
    push_exp("midlock_reset_ans2", 64'd0);    pop_check(64'(a_sans[2]));
    a_req = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();

    // Wrap-around on the single-ALU instance
    b_id[0] = 8'd2; b_id[1] = 8'd250; b_req = 2'b11;
    push_exp("wrap_first", 64'({WR_G1, 1'b1}));
    tick();                                           pop_check(st_b());
    b_rel = WR_G1; b_req = ~WR_G1;
    push_exp("wrap_release", 64'd0);
    tick();                                           pop_check(st_b());
    b_rel = 2'b00;
    push_exp("wrap_second", 64'({~WR_G1, 1'b1}));
    tick();                                           pop_check(st_b());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sic_alu_lock_arbiter.md
# sic_alu_lock_arbiter

Shares a pool of `NUM_ALU` ALUs among `NUM_SIC` SIC execution units. Each SIC raises a lock request tagged with its issue id. The arbiter grants free ALUs oldest-issue-first, holds each lock until that SIC's release pulse, and routes `alu_req_t`/`alu_ans_t` between each owner and its ALU. It sits between the SIC array and the ALU instances at core top level.

## Interface
- `NUM_SIC`, default 4: number of requesting SICs (≥1).
- `NUM_ALU`, default 2: number of shared ALUs (1..`NUM_SIC`).
- `ID_WIDTH`, default 8: issue-id width; ids wrap modulo 2^`ID_WIDTH`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  `NUM_SIC`  lock request, level, per SIC.
- `req_issue_id`  in  `NUM_SIC`×`ID_WIDTH`  issue id of each requester.
- `release_lock`  in  `NUM_SIC`  one-cycle release pulse, per SIC.
- `grant`  out  `NUM_SIC`  lock held, registered.
- `sic_alu_req`  in  `NUM_SIC`×`alu_req_t`  ALU operation from each SIC.
- `sic_alu_ans`  out  `NUM_SIC`×`alu_ans_t`  result from the SIC's owned ALU.
- `alu_req_out`  out  `NUM_ALU`×`alu_req_t`  operation driven to each ALU.
- `alu_ans_in`  in  `NUM_ALU`×`alu_ans_t`  result from each ALU.
- `alu_busy`  out  `NUM_ALU`  ALU slot owned, registered.

## Operation
- State per ALU slot k: `owner_valid[k]` and `owner_idx[k]` (`$clog2(NUM_SIC)` bits). No other FSM.
- Eligible SIC i: `req[i]`=1, SIC i owns no slot, and `release_lock[i]`=0 this cycle.
- Age order: a is older than b when `signed'(a-b) < 0` at `ID_WIDTH` width. Ties go to the lower SIC index.
- Allocation, every cycle: slots that are free at cycle start, in ascending k, each take the oldest eligible SIC not yet picked this cycle. Owner registers update at the edge.
- A slot freed by a release this cycle is not reallocated in the same cycle.
- Release: `release_lock[i]`=1 clears the slot owned by i at the edge. The level of `req[i]` does not matter.
  - Release from a non-owner is ignored. This covers an abort before grant.
- A lock is sticky. Dropping `req` without a release does not free the slot.
- `grant[i]` is 1 when some slot has `owner_valid` set and `owner_idx`=i. `alu_busy[k]` equals `owner_valid[k]`.
- Routing, combinational: `alu_req_out[k]` = `sic_alu_req[owner_idx[k]]` if owned, else `'0`. `sic_alu_ans[i]` = `alu_ans_in[k]` of the slot i owns, else `'0`.
- Invariant: a SIC owns at most one slot. A debug assertion fires on violation.
- Reset: all owners cleared. `grant`=0, `alu_busy`=0, `alu_req_out`='0, `sic_alu_ans`='0. Reset mid-lock drops every lock, with no release needed.

## Timing
- Request-to-grant: `req` sampled at cycle N with a free slot gives `grant`=1 in cycle N+1.
- Release-to-free: release at cycle M gives `grant`=0 and `alu_busy`=0 in M+1. The slot can be allocated in M+1, so the next grant appears in M+2.
- Same SIC asserting `req` and `release_lock` in one cycle: the release wins. The request is considered from the next cycle.
- Routing has zero latency. The ALU answer must be valid in the cycle after the owner drives `sic_alu_req`.
- Up to `NUM_ALU` grants can issue in one cycle.

## Configuration
- `SIC_ALU_ARB_AGE_PRIORITY_EN` defined: oldest-issue-first ordering as above.
- Undefined: fixed priority, lowest SIC index first. `req_issue_id` is ignored and the age comparators are removed.

## Structure
- `structs.svh` gains:
  - `alu_owner_t`, packed {valid, idx}.
  - Function `issue_id_older(a,b)`, the wrap-aware compare, reused by other age-ordered arbiters.
- `alu_req_t` and `alu_ans_t` stay where they are defined today.
- One sub-module, `sic_age_picker`. It is combinational: it takes an eligibility mask and the ids, and returns a one-hot of the oldest requester. Instantiate it `NUM_ALU` times in a chain, each stage masking out the previous picks.

## Test plan
- Single requester: SIC1 `req`=1, id 5, both ALUs free → `grant[1]`=1 one cycle later, slot 0 owned. Release → `grant[1]`=0 next cycle.
- Oversubscription, age: SICs 0..3 request with ids 9, 3, 7, 4 in the same cycle → next cycle SIC1 holds slot 0, SIC3 holds slot 1. SIC0 and SIC2 wait.
- Wrap-around: ids 250 and 2 (ID_WIDTH 8), one ALU → id 250 is granted first.
- Release then handoff: SIC1 releases at cycle M while SIC2 is waiting → slot free in M+1, `grant[2]`=1 in M+2. Nothing is granted at M+1.
- Abort before grant: SIC3 pulses `release_lock` while ungranted and drops `req` → no state change, no grant. A stray release from SIC0 while SIC1 owns → SIC1 keeps its lock.
- Routing plus reset mid-lock: SIC2 owns slot 1, drives op with a=10, b=3 → `alu_req_out[1]` carries those operands, and `sic_alu_ans[2]` mirrors `alu_ans_in[1]`. Assert `rst_n` low → all outputs 0 immediately.
